plaintext_serializer: RTL and testbench



---
 rtl/aes_pkg.sv | 35 +++
 rtl/plaintext_serializer_fifo.sv | 76 +++++++
 rtl/plaintext_serializer.sv | 150 +++++++++++++++
 tb/tb_plaintext_serializer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the AES decryption datapath.
//   BLOCK_W / BYTE_W / BYTES_PER_BLOCK : block geometry
//   block_t, byte_t                    : data types
//   ser_state_t                        : plaintext serializer FSM states
//   block_byte()                       : byte lane selection within a block
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int BLOCK_W         = 128;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_BLOCK = 16;

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [BYTE_W-1:0]  byte_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_t;

  // Byte idx of a block; MSB-first maps idx 0 to bits [127:120].
  function automatic byte_t block_byte(input block_t blk, input logic [3:0] idx,
                                       input logic msb_first);
    logic [3:0] lane;
    if (msb_first) begin
      lane = 4'd15 - idx;
    end else begin
      lane = idx;
    end
    return blk[{lane, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/plaintext_serializer_fifo.sv
// -----------------------------------------------------------------------------
// block_fifo
// Synchronous DEPTH x 128-bit FIFO, first-word fall-through.
//   clk, reset (sync, active-low) : clocking
//   wr_en / wr_data               : push (ignored when full unless popping)
//   rd_en / rd_data               : pop / current head
//   full, empty, count            : occupancy
// A push on a full FIFO is accepted only together with a pop, in which case
// the new word lands in the slot the head is vacating.
// -----------------------------------------------------------------------------
module block_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  block_t                 wr_data,
  input  logic                   rd_en,
  output block_t                 rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  block_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rd_ok_s, wr_ok_s;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == PW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_ok_s = rd_en && !empty;
  assign wr_ok_s = wr_en && (!full || rd_ok_s);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/plaintext_serializer.sv
// -----------------------------------------------------------------------------
// plaintext_serializer
// Captures each 128-bit plaintext block on the rising edge of done, buffers up
// to DEPTH blocks and streams them one byte per beat on a valid/ready port.
//   clk, reset (sync, active-low)
//   done, plaintext            : decryptor output (done may be level or pulse)
//   out_data/out_valid/out_last: byte stream, out_ready from consumer
//   busy                       : data buffered or being sent
//   overflow                   : sticky, a block was dropped on a full FIFO
// Optional macro PT_SER_STATS_EN adds blocks_sent[15:0] (wrapping count of
// completed blocks) and drop_count[7:0] (saturating count of dropped blocks).
// -----------------------------------------------------------------------------
module plaintext_serializer
  import aes_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        done,
  input  block_t      plaintext,
  output byte_t       out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        overflow
`ifdef PT_SER_STATS_EN
  ,
  output logic [15:0] blocks_sent,
  output logic [7:0]  drop_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  ser_state_t    state_q;
  logic [3:0]    idx_q;
  logic          out_valid_q, out_last_q;
  logic          done_q, overflow_q;

  block_t        fifo_head_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic          capture_s, accept_s, pop_s, fifo_wr_s, drop_s, more_s;

  assign capture_s = done && !done_q;
  assign accept_s  = out_valid_q && out_ready;
  assign pop_s     = accept_s && (idx_q == 4'd15);
  // A full FIFO still takes a capture when the head is popped on the same edge.
  assign fifo_wr_s = capture_s && (!fifo_full_s || pop_s);
  assign drop_s    = capture_s && fifo_full_s && !pop_s;
  // Blocks left after popping the head, counting a same-edge capture.
  assign more_s    = (fifo_count_s > CW'(1)) || fifo_wr_s;

  block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr_s),
    .wr_data (plaintext),
    .rd_en   (pop_s),
    .rd_data (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Head storage and idx are both registers and only move on an accepted
  // beat, so the selected byte holds steady while the consumer stalls.
  assign out_data  = out_valid_q ? block_byte(fifo_head_s, idx_q, MSB_FIRST) : 8'h00;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = !fifo_empty_s || (state_q == STREAM);
  assign overflow  = overflow_q;

  // Done edge detector and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q     <= done;
      overflow_q <= overflow_q || drop_s;
    end
  end

  // Stream FSM with registered valid/last and byte index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          idx_q      <= 4'd0;
          out_last_q <= 1'b0;
          if (!fifo_empty_s) begin
            state_q     <= STREAM;
            out_valid_q <= 1'b1;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        STREAM: begin
          if (accept_s) begin
            idx_q      <= idx_q + 4'd1;
            out_last_q <= (idx_q == 4'd14);
            if (pop_s && !more_s) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          idx_q       <= 4'd0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PT_SER_STATS_EN
  logic [15:0] blocks_sent_q;
  logic [7:0]  drop_count_q;

  assign blocks_sent = blocks_sent_q;
  assign drop_count  = drop_count_q;

  // Completed-block counter (wrapping) and dropped-block counter (saturating).
  always_ff @(posedge clk) begin
    if (!reset) begin
      blocks_sent_q <= 16'h0000;
      drop_count_q  <= 8'h00;
    end else begin
      if (accept_s && out_last_q) begin
        blocks_sent_q <= blocks_sent_q + 16'h0001;
      end
      if (drop_s && (drop_count_q != 8'hFF)) begin
        drop_count_q <= drop_count_q + 8'h01;
      end
    end
  end
`endif

endmodule

// File: tb/tb_plaintext_serializer.sv
module tb_plaintext_serializer;

  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset, done, out_ready;
  logic [127:0] plaintext;

  logic [7:0] m_data, l_data;
  logic       m_valid, m_last, m_busy, m_ovf;
  logic       l_valid, l_last, l_busy, l_ovf;
`ifdef PT_SER_STATS_EN
  logic [15:0] m_sent, l_sent;
  logic [7:0]  m_drop, l_drop;
`endif

  always #5 clk = ~clk;

  plaintext_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .done(done), .plaintext(plaintext),
    .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
    .out_last(m_last), .busy(m_busy), .overflow(m_ovf)
`ifdef PT_SER_STATS_EN
    , .blocks_sent(m_sent), .drop_count(m_drop)
`endif
  );

  plaintext_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .done(done), .plaintext(plaintext),
    .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
    .out_last(l_last), .busy(l_busy), .overflow(l_ovf)
`ifdef PT_SER_STATS_EN
    , .blocks_sent(l_sent), .drop_count(l_drop)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [127:0] q[$];
  int           pos;
  bit           active, prev_done, ovf, mv;
  logic [15:0]  sent;
  logic [7:0]   drops;

  function automatic logic [7:0] ref_byte(input logic [127:0] b, input int i, input bit msb);
    logic [127:0] s;
    if (msb) s = b >> (8 * (15 - i));
    else     s = b >> (8 * i);
    return s[7:0];
  endfunction

  always @(posedge clk) begin
    bit acc, popped, had_data, cap;
    if (!reset) begin
      q.delete();
      pos = 0; active = 0; prev_done = 0; ovf = 0; sent = 16'h0; drops = 8'h0; mv = 1;
    end else if (mv) begin
      had_data = (q.size() > 0);
      acc      = active && out_ready;
      popped   = acc && (pos == 15);
      if (popped) begin
        void'(q.pop_front());
        pos = 0;
        sent = sent + 16'h1;
      end else if (acc) begin
        pos = pos + 1;
      end
      cap = done && !prev_done;
      if (cap) begin
        if (q.size() < DEPTH) q.push_back(plaintext);
        else begin
          ovf = 1;
          if (drops != 8'hFF) drops = drops + 8'h1;
        end
      end
      if (!active) active = had_data;
      else if (popped) active = (q.size() > 0);
      prev_done = done;
    end
  end

  // Compare both DUTs against the model every cycle once reset was seen.
  always @(negedge clk) begin
    logic [7:0] em, el;
    if (mv) begin
      em = active ? ref_byte(q[0], pos, 1'b1) : 8'h00;
      el = active ? ref_byte(q[0], pos, 1'b0) : 8'h00;
      chk("valid",     32'(m_valid), 32'(active));
      chk("last",      32'(m_last),  32'(active && pos == 15));
      chk("busy",      32'(m_busy),  32'(active || q.size() > 0));
      chk("overflow",  32'(m_ovf),   32'(ovf));
      chk("data_msb",  32'(m_data),  32'(em));
      chk("valid_lsb", 32'(l_valid), 32'(active));
      chk("last_lsb",  32'(l_last),  32'(active && pos == 15));
      chk("busy_lsb",  32'(l_busy),  32'(active || q.size() > 0));
      chk("ovf_lsb",   32'(l_ovf),   32'(ovf));
      chk("data_lsb",  32'(l_data),  32'(el));
`ifdef PT_SER_STATS_EN
      chk("blocks_sent", 32'(m_sent), 32'(sent));
      chk("drop_count",  32'(m_drop), 32'(drops));
      chk("blocks_sent_lsb", 32'(l_sent), 32'(sent));
      chk("drop_count_lsb",  32'(l_drop), 32'(drops));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic d, input logic [127:0] p, input logic r, input logic rs);
    done = d; plaintext = p; out_ready = r; reset = rs;
    @(negedge clk);
  endtask

  localparam logic [127:0] P1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] PA = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
  localparam logic [127:0] PB = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
  localparam logic [127:0] PC = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
  localparam logic [127:0] PD = 128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF;

  initial begin
    int beats;
    logic r;
    logic d;
    // Reset
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data",  32'(m_data),  32'h00);
    chk("rst_busy",  32'(m_busy),  32'd0);
    chk("rst_ovf",   32'(m_ovf),   32'd0);

    // Test 1: single block, latency and byte order
    step(1'b1, P1, 1'b1, 1'b1);
    chk("t1_lat_valid", 32'(m_valid), 32'd0);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("t1_valid",     32'(m_valid), 32'd1);
    chk("t1_first",     32'(m_data),  32'h00);
    chk("t1_first_lsb", 32'(l_data),  32'hFF);
    chk("t1_not_last",  32'(m_last),  32'd0);
    repeat (15) step(1'b0, '0, 1'b1, 1'b1);
    chk("t1_last_byte", 32'(m_data),  32'hFF);
    chk("t1_last_flag", 32'(m_last),  32'd1);
    chk("t1_last_lsb",  32'(l_data),  32'h00);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("t1_idle",      32'(m_valid), 32'd0);
    chk("t1_busy_drop", 32'(m_busy),  32'd0);

    // Test 2: held done with alternating backpressure
    beats = 0;
    for (int i = 0; i < 50; i++) begin
      r = (i % 2 == 0);
      if (m_valid && r) beats++;
      step(i < 40, PA, r, 1'b1);
    end
    chk("t2_beats", 32'(beats), 32'd16);

    // Test 3: overflow with DEPTH=2
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, PA, 1'b0, 1'b1); step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, PB, 1'b0, 1'b1); step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, PC, 1'b0, 1'b1); step(1'b0, '0, 1'b0, 1'b1);
    chk("t3_overflow", 32'(m_ovf), 32'd1);
    chk("t3_head",     32'(m_data), 32'hA0);
    beats = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_valid) beats++;
      step(1'b0, '0, 1'b1, 1'b1);
    end
    chk("t3_beats", 32'(beats), 32'd32);

    // Test 4: capture coincides with last-byte pop on a full FIFO
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, PA, 1'b0, 1'b1); step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, PB, 1'b0, 1'b1); step(1'b0, '0, 1'b0, 1'b1);
    repeat (15) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, PD, 1'b1, 1'b1);
    chk("t4_no_ovf", 32'(m_ovf),  32'd0);
    chk("t4_b_head", 32'(m_data), 32'hB0);
    repeat (40) step(1'b0, '0, 1'b1, 1'b1);

    // Test 5: reset mid-stream
    step(1'b1, P1, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    repeat (5) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t5_valid", 32'(m_valid), 32'd0);
    chk("t5_busy",  32'(m_busy),  32'd0);
    chk("t5_ovf",   32'(m_ovf),   32'd0);
    step(1'b1, PB, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("t5_restart", 32'(m_data), 32'hB0);
    repeat (20) step(1'b0, '0, 1'b1, 1'b1);

    // Test 6: two blocks, LSB-first instance and stats
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, P1, 1'b1, 1'b1); step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, P1, 1'b1, 1'b1);
    repeat (40) step(1'b0, '0, 1'b1, 1'b1);
`ifdef PT_SER_STATS_EN
    chk("t6_sent", 32'(l_sent), 32'd2);
    chk("t6_drop", 32'(l_drop), 32'd0);
`endif

    // Randomized phase: low ready early to force drops, rare resets
    d = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) d = ~d;
      if (i < 1500) r = ($urandom_range(3) == 0);
      else          r = ($urandom_range(3) != 0);
      step(d, {$urandom, $urandom, $urandom, $urandom}, r, ($urandom_range(499) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
